mem_port_arbiter: RTL and testbench

- Shares one external memory port between the instruction-fetch (IF) requester and the data-memory (MEM stage) requester, one transaction at a time.
- Drives data_ready_mem, which stalls the pipeline registers and program counter while a data access is pending.
- Data requests have fixed priority, bounded by a starvation limit that guarantees instruction fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Grant registers mem_* one cycle after request; completion is flagged in the cycle after mem_ack; requesters hold req while data_ready_mem/if_valid stays low.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              data_ready_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       cancel_flag;
    logic       done_d;
    logic       grant_d;
    logic       grant_i;
    logic       ack_d;
    logic       ack_i;

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless a waiting fetch has already been passed over LIMIT times.
                if (dm_req && !(if_req && starve_cnt == LIMIT)) begin
                    grant_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (if_req && !if_cancel) begin
                    grant_i   = 1'b1;
                    state_nxt = I_BUSY;
                end
            end
            D_BUSY:  if (mem_ack) state_nxt = DONE;
            I_BUSY:  if (mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ack_d = (state == D_BUSY) && mem_ack;
    assign ack_i = (state == I_BUSY) && mem_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_valid    <= 1'b0;
            done_d      <= 1'b0;
            starve_cnt  <= '0;
            cancel_flag <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            done_d   <= 1'b0;
            if (grant_d) begin
                mem_req    <= 1'b1;
                mem_we     <= dm_we;
                mem_addr   <= dm_addr;
                mem_wdata  <= dm_wdata;
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
            if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                starve_cnt <= '0;
            end
            if ((state == I_BUSY) && if_cancel) begin
                cancel_flag <= 1'b1;
            end
            if (ack_d) begin
                mem_req <= 1'b0;
                done_d  <= 1'b1;
                if (!mem_we) begin
                    dm_rdata <= mem_rdata;
                end
            end
            if (ack_i) begin
                mem_req     <= 1'b0;
                if_rdata    <= mem_rdata;
                if_valid    <= !(cancel_flag || if_cancel);
                cancel_flag <= 1'b0;
            end
        end
    end

    assign data_ready_mem = ~dm_req | done_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_cancel = 1'b0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          data_ready_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .data_ready_mem(data_ready_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model: who owns the port, whether this is the one-cycle completion slot,
    // how many data grants in a row have overtaken a waiting fetch
    int            m_owner;      // 0 nobody, 1 data, 2 fetch
    bit            m_cooldown;
    int            m_streak;
    bit            m_killed;
    logic          m_mem_req, m_mem_we;
    logic [AW-1:0] m_mem_addr;
    logic [DW-1:0] m_mem_wdata, m_if_rdata, m_dm_rdata;
    bit            m_if_valid, m_dm_done;

    // environment
    bit            rnd = 0, dm_hold = 0, if_hold = 0, use_fixed = 0;
    logic [DW-1:0] fixed_rdata = '0;
    int            fix_lat = 0, mlat = 0, mcyc = 0;
    bit            dm_fin = 0, if_fin = 0, last_req = 0;
    int            cyc = 0, last_dm_done_cyc = 0, last_ifv_cyc = 0;
    int            drm_low = 0, ifv_cnt = 0, req_pulses = 0;
    logic [AW-1:0] grants[$];
    logic          g_we;
    logic [DW-1:0] g_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_owner = 0; m_cooldown = 0; m_streak = 0; m_killed = 0;
        m_mem_req = 0; m_mem_we = 0; m_mem_addr = '0; m_mem_wdata = '0;
        m_if_rdata = '0; m_dm_rdata = '0; m_if_valid = 0; m_dm_done = 0;
    endfunction

    function automatic void model_step();
        bit was_done;
        was_done   = m_cooldown;
        m_cooldown = 0;
        m_if_valid = 0;
        m_dm_done  = 0;
        if (was_done) begin
            // completion slot: nothing is granted
        end else if (m_owner == 0) begin
            if (dm_req && !(if_req && m_streak >= LIM)) begin
                m_owner = 1; m_mem_req = 1; m_mem_we = dm_we;
                m_mem_addr = dm_addr; m_mem_wdata = dm_wdata;
                m_streak = if_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
            end else if (if_req && !if_cancel) begin
                m_owner = 2; m_mem_req = 1; m_mem_we = 0; m_mem_addr = if_addr;
                m_streak = 0;
            end
        end else begin
            if (m_owner == 2 && if_cancel) m_killed = 1;
            if (mem_ack) begin
                if (m_owner == 1) begin
                    if (!m_mem_we) m_dm_rdata = mem_rdata;
                    m_dm_done = 1;
                end else begin
                    m_if_rdata = mem_rdata;
                    m_if_valid = !m_killed;
                    m_killed   = 0;
                end
                m_mem_req = 0; m_owner = 0; m_cooldown = 1;
            end
        end
    endfunction

    task automatic compare_all();
        chk("mem_req",   mem_req,   m_mem_req);
        chk("mem_we",    mem_we,    m_mem_we);
        chk("mem_addr",  mem_addr,  m_mem_addr);
        chk("mem_wdata", mem_wdata, m_mem_wdata);
        chk("if_rdata",  if_rdata,  m_if_rdata);
        chk("if_valid",  if_valid,  m_if_valid);
        chk("dm_rdata",  dm_rdata,  m_dm_rdata);
    endtask

    task automatic dm_new_random();
        dm_req   = ($urandom_range(0, 3) != 0);
        dm_we    = $urandom_range(0, 1);
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
    endtask

    // one clock cycle: requesters, memory, combinational check, model, registered check
    task automatic tick();
        if (dm_fin) begin
            if (rnd) dm_new_random();
            else if (!dm_hold) dm_req = 0;
        end else if (rnd && !dm_req && $urandom_range(0, 2) == 0) begin
            dm_new_random();
        end
        if (rnd) begin
            if (if_fin) begin
                if_cancel = 0;
                if_req    = ($urandom_range(0, 3) != 0);
                if_addr   = $urandom & 32'hFFFF_FFFC;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req    = 1;
                if_addr   = $urandom & 32'hFFFF_FFFC;
                if_cancel = 0;
            end else begin
                if_cancel = if_req && ($urandom_range(0, 15) == 0);
            end
        end else if (if_fin && !if_hold) begin
            if_req = 0;
        end

        if (mem_req) begin
            if (mcyc == 0) mlat = rnd ? $urandom_range(0, 3) : fix_lat;
            mem_ack = (mcyc >= mlat);
            mcyc++;
        end else begin
            mcyc    = 0;
            mem_ack = rnd && ($urandom_range(0, 7) == 0);
        end
        mem_rdata = use_fixed ? fixed_rdata : $urandom;

        #1;
        chk("data_ready_mem", data_ready_mem, (!dm_req) || m_dm_done);
        if (!data_ready_mem) drm_low++;
        dm_fin = dm_req && m_dm_done;
        if (dm_fin) last_dm_done_cyc = cyc;
        if_fin = if_req && (m_if_valid || if_cancel);
        model_step();

        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (if_valid) begin
            ifv_cnt++;
            last_ifv_cyc = cyc;
        end
        if (mem_req && !last_req) begin
            grants.push_back(mem_addr);
            g_we    = mem_we;
            g_wdata = mem_wdata;
            req_pulses++;
        end
        last_req = mem_req;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   mem_req,   1'b0);
        chk({tag, "_mem_we"},    mem_we,    1'b0);
        chk({tag, "_mem_addr"},  mem_addr,  32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_if_rdata"},  if_rdata,  32'h0);
        chk({tag, "_dm_rdata"},  dm_rdata,  32'h0);
        chk({tag, "_if_valid"},  if_valid,  1'b0);
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        int n;

        model_reset();
        #2 rstn = 0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        chk("reset_drm", data_ready_mem, 1'b1);
        rstn = 1;

        // load with minimum latency
        use_fixed = 1; fixed_rdata = 32'hDEADBEEF; fix_lat = 0;
        drm_low = 0; req_pulses = 0; grants.delete();
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_wdata = 32'h0;
        repeat (6) tick();
        chk("load_stall_cycles", drm_low, 2);
        chk("load_rdata", dm_rdata, 32'hDEADBEEF);
        chk("model_load_rdata", m_dm_rdata, 32'hDEADBEEF);
        chk("load_pulses", req_pulses, 1);

        // store leaves dm_rdata alone
        drm_low = 0; grants.delete();
        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
        repeat (6) tick();
        chk("store_n", grants.size(), 1);
        if (grants.size() > 0) chk("store_addr", grants[0], 32'h80);
        chk("store_we", g_we, 1'b1);
        chk("store_wdata", g_wdata, 32'h12345678);
        chk("store_rdata_kept", dm_rdata, 32'hDEADBEEF);
        chk("store_stall_cycles", drm_low, 2);

        // simultaneous requests: data first, fetch after data completes
        use_fixed = 0; grants.delete(); ifv_cnt = 0;
        if_req = 1; if_addr = 32'h0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        repeat (8) tick();
        chk("simul_n", grants.size(), 2);
        if (grants.size() > 1) begin
            chk("simul_first", grants[0], 32'h200);
            chk("simul_second", grants[1], 32'h0);
        end
        chk("simul_ifv_n", ifv_cnt, 1);
        chk("simul_ifv_delay", last_ifv_cyc - last_dm_done_cyc, 3);

        // starvation: both held, fetch forced through after LIM data grants
        grants.delete(); dm_hold = 1; if_hold = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        if_req = 1; if_addr = 32'h40;
        n = 0;
        while (grants.size() < 10 && n < 200) begin tick(); n++; end
        dm_hold = 0; if_hold = 0;
        n = 0;
        while ((dm_req || if_req) && n < 60) begin tick(); n++; end
        chk("starve_drained", dm_req || if_req, 1'b0);
        repeat (3) tick();
        chk("starve_n", grants.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            exp_addr = (i % 5 == 4) ? 32'h40 : 32'h300;
            chk($sformatf("starve_grant%0d", i), grants[i], exp_addr);
        end

        // cancel during a slow fetch
        fix_lat = 3; ifv_cnt = 0; grants.delete();
        if_req = 1; if_addr = 32'h44;
        n = 0;
        while (!mem_req && n < 10) begin tick(); n++; end
        tick();
        if_cancel = 1;
        tick();
        if_cancel = 0;
        repeat (8) tick();
        chk("cancel_ifv_n", ifv_cnt, 0);
        chk("cancel_idle", mem_req, 1'b0);
        chk("cancel_n", grants.size(), 1);
        if (grants.size() > 0) chk("cancel_addr", grants[0], 32'h44);

        // reset mid-transaction
        grants.delete();
        dm_req = 1; dm_we = 0; dm_addr = 32'h500;
        n = 0;
        while (!mem_req && n < 10) begin tick(); n++; end
        tick();
        chk("midrst_busy", mem_req, 1'b1);
        #2 rstn = 0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        dm_req = 0; mem_ack = 0;
        @(posedge clk); @(posedge clk); #1;
        compare_all();
        rstn = 1; mcyc = 0; last_req = 0; dm_fin = 0; if_fin = 0;
        grants.delete();
        fix_lat = 0; use_fixed = 1; fixed_rdata = 32'hCAFEF00D;
        dm_req = 1; dm_we = 0; dm_addr = 32'h600;
        repeat (6) tick();
        chk("postrst_rdata", dm_rdata, 32'hCAFEF00D);
        chk("postrst_n", grants.size(), 1);
        if (grants.size() > 0) chk("postrst_addr", grants[0], 32'h600);

        // randomized traffic
        use_fixed = 0; rnd = 1;
        repeat (3000) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
